// File: rtl/glyph_pkg.sv
// Shared types, geometry constants and candidate-code sequencing for the glyph matcher.
// Latency: n/a (package). Backpressure: n/a.
// Contents: GLYPH_W/H/PIX, state_t, next_t, is_mapped(), next_mapped(), first_mapped().
// Config macro: GLYPH_EXT_CODES_EN -- when defined, the search continues to 164 then 253 after the base range.
package glyph_pkg;

  localparam int GLYPH_W   = 5;
  localparam int GLYPH_H   = 8;
  localparam int GLYPH_PIX = GLYPH_W * GLYPH_H;

  typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;

  typedef struct packed {
    logic       vld;   // 0 = no further candidate
    logic [7:0] code;
  } next_t;

  // Codes whose ROM entry is a real glyph. Excluded codes fall back to the
  // ROM's default period glyph and would otherwise shadow a genuine '.'.
  function automatic logic is_mapped(input logic [7:0] code);
    logic m;
    m = (code >= 8'd32) && (code <= 8'd127);
    case (code)
      8'd39, 8'd59, 8'd64,
      8'd91, 8'd92, 8'd93, 8'd94, 8'd95, 8'd96,
      8'd123, 8'd125: m = 1'b0;
      8'd164, 8'd253: m = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  // Next mapped code strictly above 'code'. The longest excluded run is six
  // codes (91..96), so an eight-step lookahead always reaches a mapped code.
  function automatic next_t next_mapped(input logic [7:0] code, input logic [7:0] last_code);
    next_t      r;
    logic [8:0] c;
    r = '0;
    for (int i = 1; i <= 8; i++) begin
      c = {1'b0, code} + 9'(i);
      if (!r.vld && (c <= {1'b0, last_code}) && is_mapped(c[7:0])) begin
        r.vld  = 1'b1;
        r.code = c[7:0];
      end
    end
`ifdef GLYPH_EXT_CODES_EN
    if (!r.vld) begin
      if (code < 8'd164) begin
        r.vld  = 1'b1;
        r.code = 8'd164;
      end else if (code < 8'd253) begin
        r.vld  = 1'b1;
        r.code = 8'd253;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [7:0] first_mapped(input logic [7:0] code, input logic [7:0] last_code);
    next_t n;
    n = next_mapped(code, last_code);
    return is_mapped(code) ? code : n.code;
  endfunction

endpackage

// File: rtl/glyph_matcher_if.sv
// Bundles the bitmap input stream, glyph ROM lookup and result stream of the glyph matcher.
// Latency: n/a (wiring only). Backpressure: in_valid/in_ready and res_valid/res_ready handshakes.
// Modports: master = matcher side, slave = environment (source, ROM, sink).
interface glyph_matcher_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_pixel;
  logic [7:0] rom_select;
  logic [2:0] rom_x;
  logic [2:0] rom_y;
  logic       rom_pixel;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_code;
  logic       res_found;

  modport master (
    input  in_valid, in_pixel, rom_pixel, res_ready,
    output in_ready, rom_select, rom_x, rom_y, res_valid, res_code, res_found
  );

  modport slave (
    output in_valid, in_pixel, rom_pixel, res_ready,
    input  in_ready, rom_select, rom_x, rom_y, res_valid, res_code, res_found
  );

endinterface

// File: rtl/glyph_capture.sv
// 40-bit bitmap store with a shared pixel index p and its (x, y) decomposition.
// Latency: write/advance take effect on the next edge; pix_out/p_last are combinational from p.
// Backpressure: none internally; the caller only asserts load_en/step when a pixel is to be consumed.
// Ports: clk, rst_n; clr (p,x,y -> 0, wins over advance); load_en (store pix_in at p and advance);
//        step (advance without storing); pix_in; pix_out = bitmap[p]; p_last = (p == 39); x, y.
module glyph_capture
  import glyph_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load_en,
  input  logic       step,
  input  logic       pix_in,
  output logic       pix_out,
  output logic       p_last,
  output logic [2:0] x,
  output logic [2:0] y
);

  logic [GLYPH_PIX-1:0] bitmap_q;
  logic [5:0]           p_q;
  logic [2:0]           x_q;
  logic [2:0]           y_q;

  // x/y run alongside p so the ROM coordinates never need a divide-by-5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q <= '0;
      p_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      if (load_en) begin
        bitmap_q[p_q] <= pix_in;
      end
      if (clr) begin
        p_q <= '0;
        x_q <= '0;
        y_q <= '0;
      end else if (load_en || step) begin
        p_q <= p_q + 6'd1;
        if (x_q == 3'(GLYPH_W - 1)) begin
          x_q <= '0;
          y_q <= y_q + 3'd1;
        end else begin
          x_q <= x_q + 3'd1;
        end
      end
    end
  end

  assign pix_out = bitmap_q[p_q];
  assign p_last  = (p_q == 6'(GLYPH_PIX - 1));
  assign x       = x_q;
  assign y       = y_q;

endmodule

// File: rtl/glyph_matcher.sv
// Finds the character code whose 5x8 ROM glyph equals a serially loaded bitmap (inverse glyph ROM).
// Latency: 40 load beats, then k+1 cycles per rejected candidate (k = first mismatching pixel), 40 for the hit.
// Backpressure: in_ready low outside LOAD; result held in DONE until res_ready; in_valid low stalls loading.
// Ports: clk, rst_n; bus (glyph_matcher_if.master): in_valid/in_ready/in_pixel bitmap stream,
//        rom_select/rom_x/rom_y -> external glyph ROM -> rom_pixel, res_valid/res_ready/res_code/res_found.
// Config macro: GLYPH_EXT_CODES_EN -- also tries codes 164 and 253 after LAST_CODE.
module glyph_matcher
  import glyph_pkg::*;
#(
  parameter logic [7:0] FIRST_CODE    = 8'd32,
  parameter logic [7:0] LAST_CODE     = 8'd127,
  parameter logic [7:0] NOTFOUND_CODE = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  glyph_matcher_if.master bus
);

  localparam logic [7:0] FIRST_MAPPED = first_mapped(FIRST_CODE, LAST_CODE);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cand_q;
  logic [7:0] res_code_q;
  logic       res_found_q;

  logic       cap_clr;
  logic       cap_load;
  logic       cap_step;
  logic       bit_p;
  logic       p_last;
  logic       match;
  next_t      nxt;

  glyph_capture u_capture (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cap_clr),
    .load_en (cap_load),
    .step    (cap_step),
    .pix_in  (bus.in_pixel),
    .pix_out (bit_p),
    .p_last  (p_last),
    .x       (bus.rom_x),
    .y       (bus.rom_y)
  );

  assign match = (bus.rom_pixel == bit_p);
  // Excluded codes are skipped here, so a candidate change never costs a cycle.
  assign nxt   = next_mapped(cand_q, LAST_CODE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:   if (bus.in_valid && p_last) state_d = SEARCH;
      SEARCH: begin
        if (match && p_last)      state_d = DONE;
        else if (!match && !nxt.vld) state_d = DONE;
      end
      DONE:   if (bus.res_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Outputs and capture control
  always_comb begin
    bus.in_ready  = (state_q == LOAD);
    bus.res_valid = (state_q == DONE);
    cap_load      = 1'b0;
    cap_step      = 1'b0;
    cap_clr       = 1'b0;
    case (state_q)
      LOAD: begin
        cap_load = bus.in_valid;
        cap_clr  = bus.in_valid && p_last;
      end
      SEARCH: begin
        cap_step = match && !p_last;
        // Restart at p=0 for the next candidate, and leave p=0 for DONE/LOAD.
        cap_clr  = !match || p_last;
      end
      default: ;
    endcase
  end

  // Candidate sequencing and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q      <= FIRST_CODE;
      res_code_q  <= NOTFOUND_CODE;
      res_found_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: if (bus.in_valid && p_last) cand_q <= FIRST_MAPPED;
        SEARCH: begin
          if (match && p_last) begin
            res_code_q  <= cand_q;
            res_found_q <= 1'b1;
          end else if (!match) begin
            if (nxt.vld) begin
              cand_q <= nxt.code;
            end else begin
              res_code_q  <= NOTFOUND_CODE;
              res_found_q <= 1'b0;
            end
          end
        end
        DONE: if (bus.res_ready) cand_q <= FIRST_CODE;
        default: ;
      endcase
    end
  end

  assign bus.rom_select = cand_q;
  assign bus.res_code   = res_code_q;
  assign bus.res_found  = res_found_q;

endmodule

// File: tb/tb_glyph_matcher.sv
// Directed bench for glyph_matcher with a small behavioural glyph ROM beside it.
module tb_glyph_matcher;

  logic clk;
  logic rst_n;

  glyph_matcher_if bus ();

  glyph_matcher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bitmaps as {row7,...,row0}, each row with x0 at its LSB, so bit p = 5*y + x.
  localparam logic [39:0] BM_ZERO   = 40'h0;
  localparam logic [39:0] BM_ONES   = {40{1'b1}};
  localparam logic [39:0] BM_A      = {5'b10001, 5'b10001, 5'b10001, 5'b11111,
                                       5'b10001, 5'b10001, 5'b10001, 5'b01110};
  localparam logic [39:0] BM_SEVEN  = {5'b00000, 5'b00010, 5'b00010, 5'b00010,
                                       5'b00100, 5'b01000, 5'b10000, 5'b11111};
  localparam logic [39:0] BM_PERIOD = {5'b00110, 5'b00110, 30'b0};

  // Reference ROM: real glyphs for the tested characters, a unique synthetic
  // glyph for every other valid code, and the period for unassigned codes.
  function automatic logic [39:0] glyph_of(input logic [7:0] c);
    logic valid;
    valid = ((c >= 8'd32) && (c <= 8'd127) &&
             !(c == 8'd39 || c == 8'd59 || c == 8'd64 || (c >= 8'd91 && c <= 8'd96) ||
               c == 8'd123 || c == 8'd125)) || c == 8'd164 || c == 8'd253;
    if (c == 8'd32)      return BM_ZERO;
    else if (c == 8'd46) return BM_PERIOD;
    else if (c == 8'd55) return BM_SEVEN;
    else if (c == 8'd65) return BM_A;
    else if (valid)      return {5'b10101, 20'b0, {2'b00, c[7:5]}, c[4:0], 5'b11111};
    else                 return BM_PERIOD;
  endfunction

  function automatic logic rom_pix(input logic [7:0] c, input logic [2:0] x, input logic [2:0] y);
    logic [39:0] g;
    int          idx;
    g   = glyph_of(c);
    idx = 5 * int'(y) + int'(x);
    return (idx < 40) ? g[idx] : 1'b0;
  endfunction

  assign bus.rom_pixel = rom_pix(bus.rom_select, bus.rom_x, bus.rom_y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int search_cycles;
  int ready_viol;
  bit saw164;
  bit saw253;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string w);
    chk({w, "_in_ready"},   32'(bus.in_ready),   1);
    chk({w, "_res_valid"},  32'(bus.res_valid),  0);
    chk({w, "_res_code"},   32'(bus.res_code),   0);
    chk({w, "_res_found"},  32'(bus.res_found),  0);
    chk({w, "_rom_select"}, 32'(bus.rom_select), 32);
    chk({w, "_rom_x"},      32'(bus.rom_x),      0);
    chk({w, "_rom_y"},      32'(bus.rom_y),      0);
  endtask

  // Drives n pixels of bm, optionally with idle cycles between beats.
  task automatic load_bitmap(input logic [39:0] bm, input bit gaps, input int n);
    for (int p = 0; p < n; p++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_pixel = bm[p];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_pixel = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    search_cycles = 0;
    ready_viol    = 0;
    saw164        = 1'b0;
    saw253        = 1'b0;
    while (!bus.res_valid && search_cycles < 5000) begin
      if (bus.in_ready) ready_viol++;
      if (bus.rom_select == 8'd164) saw164 = 1'b1;
      if (bus.rom_select == 8'd253) saw253 = 1'b1;
      @(posedge clk); #1;
      search_cycles++;
    end
    chk({tag, "_res_valid"},  32'(bus.res_valid), 1);
    chk({tag, "_ready_low"},  32'(ready_viol),    0);
  endtask

  task automatic release_result(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, "_rel_in_ready"},  32'(bus.in_ready),  1);
    chk({tag, "_rel_res_valid"}, 32'(bus.res_valid), 0);
  endtask

  initial begin
    int bad;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = 1'b0;
    bus.res_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1 chk_reset("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // All-zero bitmap: space matches first, 40 search cycles.
    load_bitmap(BM_ZERO, 1'b0, 40);
    wait_result("zero");
    chk("zero_cycles", 32'(search_cycles), 40);
    chk("zero_code",   32'(bus.res_code),  32);
    chk("zero_found",  32'(bus.res_found), 1);
    release_result("zero");

    // 'A' with source gaps, then a long hold in DONE.
    load_bitmap(BM_A, 1'b1, 40);
    wait_result("A");
    chk("A_code",  32'(bus.res_code),  65);
    chk("A_found", 32'(bus.res_found), 1);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b1 || bus.res_code !== 8'd65 ||
          bus.res_found !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    chk("A_hold_stable", 32'(bad), 0);
    release_result("A");

    // Period: excluded code 39 carries the same ROM glyph and must be skipped.
    load_bitmap(BM_PERIOD, 1'b0, 40);
    wait_result("period");
    chk("period_code",  32'(bus.res_code),  46);
    chk("period_found", 32'(bus.res_found), 1);
    release_result("period");

    // All-ones: nothing matches.
    load_bitmap(BM_ONES, 1'b1, 40);
    wait_result("ones");
    chk("ones_code",  32'(bus.res_code),  0);
    chk("ones_found", 32'(bus.res_found), 0);
`ifdef GLYPH_EXT_CODES_EN
    chk("ones_saw164", 32'(saw164), 1);
    chk("ones_saw253", 32'(saw253), 1);
`else
    chk("ones_saw164", 32'(saw164), 0);
    chk("ones_saw253", 32'(saw253), 0);
`endif
    release_result("ones");

    // Reset mid-LOAD, then a clean '7'.
    load_bitmap(BM_A, 1'b1, 17);
    #3 rst_n = 1'b0;
    #1 chk_reset("rst_load");
    @(posedge clk); #1 rst_n = 1'b1;
    load_bitmap(BM_SEVEN, 1'b1, 40);
    wait_result("seven1");
    chk("seven1_code",  32'(bus.res_code),  55);
    chk("seven1_found", 32'(bus.res_found), 1);
    release_result("seven1");

    // Reset mid-SEARCH, then '7' again.
    load_bitmap(BM_A, 1'b0, 40);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset("rst_search");
    @(posedge clk); #1 rst_n = 1'b1;
    load_bitmap(BM_SEVEN, 1'b0, 40);
    wait_result("seven2");
    chk("seven2_code",  32'(bus.res_code),  55);
    chk("seven2_found", 32'(bus.res_found), 1);
    release_result("seven2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
